sd_sector_arbiter: RTL and testbench

Shares the single SD sector-transfer channel (sd_lba/rd/wr/ack/buff_*) between NUM_REQ sector requesters, e.g. two floppy controller instances, or a floppy controller plus a cassette or ROM loader.
- Grants one requester at a time, round-robin.
- Latches the requester's LBA and command, and sequences the upstream handshake.
- Steers ack and buffer traffic to the granted requester only.
- Sits between the device instances and the top-level SD bus.

---
 rtl/sd_arb_pkg.sv | 19 +
 rtl/sd_arb_rr_pick.sv | 28 ++
 rtl/sd_sector_arbiter.sv | 133 +++++++++++++
 tb/tb_sd_sector_arbiter.sv | 339 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sd_arb_pkg.sv
// Shared types and constants for the SD sector-transfer arbiter.
package sd_arb_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ISSUE   = 2'd1,
    XFER    = 2'd2,
    RELEASE = 2'd3
  } sd_arb_state_t;

  typedef enum logic {
    CMD_RD = 1'b0,
    CMD_WR = 1'b1
  } sd_arb_cmd_t;

  // Roughly a quarter second at 48 MHz before a silent SD host is abandoned.
  localparam logic [23:0] SD_ARB_TIMEOUT_DEFAULT = 24'd12_000_000;

endpackage

// File: rtl/sd_arb_rr_pick.sv
// Combinational round-robin picker: the first pending index strictly after
// the last-granted pointer, wrapping around.
module sd_arb_rr_pick #(
  parameter int NUM_REQ = 2
) (
  input  logic [NUM_REQ-1:0]         pending,
  input  logic [$clog2(NUM_REQ)-1:0] last,
  output logic                       valid,
  output logic [$clog2(NUM_REQ)-1:0] index
);

  localparam int IW = $clog2(NUM_REQ);

  // Outer loop walks priority order, inner loop matches the wrapped slot.
  always_comb begin
    valid = 1'b0;
    index = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      for (int i = 0; i < NUM_REQ; i++) begin
        if (!valid && pending[i] && (i == (int'(last) + k) % NUM_REQ)) begin
          valid = 1'b1;
          index = IW'(i);
        end
      end
    end
  end

endmodule

// File: rtl/sd_sector_arbiter.sv
// Round-robin arbiter sharing one SD sector channel between NUM_REQ requesters.
// Optional ISSUE watchdog enabled by defining SD_ARB_TIMEOUT_EN.
//
// state   | meaning
// IDLE    | no grant; waits for a pending request with sd_ack low
// ISSUE   | sd_rd/sd_wr asserted for the granted requester until sd_ack
// XFER    | sd_ack high, ack/buffer traffic routed; waits for sd_ack low
// RELEASE | one cycle; last pointer updated, then back to IDLE
module sd_sector_arbiter
  import sd_arb_pkg::*;
#(
  parameter int          NUM_REQ        = 2,
  parameter int          LBA_W          = 32,
  parameter logic [23:0] TIMEOUT_CYCLES = SD_ARB_TIMEOUT_DEFAULT
) (
  input  logic                            clk,
  input  logic                            reset_n,
  input  logic [NUM_REQ-1:0][LBA_W-1:0]   req_lba,
  input  logic [NUM_REQ-1:0]              req_rd,
  input  logic [NUM_REQ-1:0]              req_wr,
  input  logic [NUM_REQ-1:0][7:0]         req_buff_din,
  output logic [NUM_REQ-1:0]              req_ack,
  output logic [NUM_REQ-1:0]              req_buff_wr,
  output logic [NUM_REQ-1:0]              req_err,
  output logic [LBA_W-1:0]                sd_lba,
  output logic                            sd_rd,
  output logic                            sd_wr,
  input  logic                            sd_ack,
  input  logic                            sd_buff_wr,
  output logic [7:0]                      sd_buff_din,
  output logic [$clog2(NUM_REQ)-1:0]      grant_id,
  output logic                            busy
);

  localparam int GW = $clog2(NUM_REQ);

  sd_arb_state_t      state, state_n;
  sd_arb_cmd_t        cmd_q;
  logic [GW-1:0]      grant_q;
  logic [GW-1:0]      last_q;
  logic [LBA_W-1:0]   lba_q;
  logic [NUM_REQ-1:0] pending;
  logic               pick_valid;
  logic [GW-1:0]      pick_idx;
  logic               take;
  logic               tmo_hit;
  logic               route;

  assign pending = req_rd | req_wr;

  sd_arb_rr_pick #(.NUM_REQ(NUM_REQ)) u_pick (
    .pending (pending),
    .last    (last_q),
    .valid   (pick_valid),
    .index   (pick_idx)
  );

  // A stale sd_ack (e.g. held across a reset) blocks new grants.
  always_comb begin
    state_n = state;
    take    = 1'b0;
    case (state)
      IDLE: begin
        if (pick_valid && !sd_ack) begin
          state_n = ISSUE;
          take    = 1'b1;
        end
      end
      ISSUE: begin
        if (sd_ack)       state_n = XFER;
        else if (tmo_hit) state_n = RELEASE;
      end
      XFER: begin
        if (!sd_ack) state_n = RELEASE;
      end
      RELEASE: state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state   <= IDLE;
      cmd_q   <= CMD_RD;
      grant_q <= '0;
      last_q  <= GW'(NUM_REQ - 1);
      lba_q   <= '0;
    end else begin
      state <= state_n;
      if (take) begin
        grant_q <= pick_idx;
        lba_q   <= req_lba[pick_idx];
        cmd_q   <= req_rd[pick_idx] ? CMD_RD : CMD_WR;
      end
      if (state == RELEASE) last_q <= grant_q;
    end
  end

`ifdef SD_ARB_TIMEOUT_EN
  logic [23:0]        tmo_cnt;
  logic [NUM_REQ-1:0] err_q;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      tmo_cnt <= '0;
      err_q   <= '0;
    end else begin
      tmo_cnt <= (state == ISSUE) ? tmo_cnt + 24'd1 : '0;
      err_q   <= (state == ISSUE && !sd_ack && tmo_hit) ?
                 (NUM_REQ'(1) << grant_q) : '0;
    end
  end

  assign tmo_hit = (tmo_cnt == TIMEOUT_CYCLES - 24'd1);
  assign req_err = err_q;
`else
  logic [23:0] unused_tmo_cfg;
  assign unused_tmo_cfg = TIMEOUT_CYCLES;
  assign tmo_hit        = 1'b0;
  assign req_err        = '0;
`endif

  assign route       = (state == ISSUE) || (state == XFER);
  assign req_ack     = route ? (NUM_REQ'(sd_ack) << grant_q) : '0;
  assign req_buff_wr = route ? (NUM_REQ'(sd_buff_wr) << grant_q) : '0;
  assign sd_buff_din = req_buff_din[grant_q];
  assign sd_rd       = (state == ISSUE) && (cmd_q == CMD_RD);
  assign sd_wr       = (state == ISSUE) && (cmd_q == CMD_WR);
  assign sd_lba      = lba_q;
  assign grant_id    = grant_q;
  assign busy        = (state != IDLE);

endmodule

// File: tb/tb_sd_sector_arbiter.sv
// Self-checking bench for sd_sector_arbiter with a round-robin reference model.
module tb_sd_sector_arbiter;

  localparam int N  = 2;
  localparam int LW = 32;
  localparam int GW = $clog2(N);

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                  reset_n;
  logic [N-1:0][LW-1:0]  req_lba;
  logic [N-1:0]          req_rd, req_wr, req_ack, req_buff_wr, req_err;
  logic [N-1:0][7:0]     req_buff_din;
  logic [LW-1:0]         sd_lba;
  logic                  sd_rd, sd_wr, sd_ack, sd_buff_wr, busy;
  logic [7:0]            sd_buff_din;
  logic [GW-1:0]         grant_id;

  int errors = 0;
  int checks = 0;
  int last_ptr = N - 1;

  sd_sector_arbiter #(
    .NUM_REQ(N), .LBA_W(LW), .TIMEOUT_CYCLES(24'd100)
  ) dut (
    .clk(clk), .reset_n(reset_n),
    .req_lba(req_lba), .req_rd(req_rd), .req_wr(req_wr),
    .req_buff_din(req_buff_din), .req_ack(req_ack),
    .req_buff_wr(req_buff_wr), .req_err(req_err),
    .sd_lba(sd_lba), .sd_rd(sd_rd), .sd_wr(sd_wr), .sd_ack(sd_ack),
    .sd_buff_wr(sd_buff_wr), .sd_buff_din(sd_buff_din),
    .grant_id(grant_id), .busy(busy)
  );

  // Reference: first pending requester at distance 1..N after the last grant.
  function automatic int rr_expect(input logic [N-1:0] pend, input int last);
    for (int d = 1; d <= N; d++)
      if (pend[(last + d) % N]) return (last + d) % N;
    return -1;
  endfunction

  task automatic reset_clear();
    @(negedge clk);
    reset_n = 1'b0;
    req_rd = '0;
    req_wr = '0;
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    last_ptr = N - 1;
  endtask

  // Plays the SD host for one granted transfer and checks routing throughout.
  task automatic serve(input int exp_gid, input bit exp_rd, input logic [LW-1:0] exp_lba,
                       input int delay, input int nbuf);
    int n;
    int seen;
    int stray;
    bit held;
    logic [N-1:0] exp_v;
    exp_v = '0;
    exp_v[exp_gid] = 1'b1;
    n = 0;
    while (!(sd_rd || sd_wr) && n < 200) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (!(sd_rd || sd_wr)) begin
      errors++;
      $display("FAIL issue_wait: no sd_rd/sd_wr after %0d cycles, required an issue", n);
      return;
    end
    checks++;
    if (grant_id !== GW'(exp_gid)) begin
      errors++;
      $display("FAIL grant_id: got %0d, required %0d", grant_id, exp_gid);
    end
    checks++;
    if (sd_lba !== exp_lba) begin
      errors++;
      $display("FAIL sd_lba: got %h, required %h", sd_lba, exp_lba);
    end
    checks++;
    if (sd_rd !== exp_rd || sd_wr !== !exp_rd) begin
      errors++;
      $display("FAIL command: got rd=%b wr=%b, required rd=%b wr=%b", sd_rd, sd_wr, exp_rd, !exp_rd);
    end
    held = 1'b1;
    repeat (delay) begin
      @(negedge clk);
      if (sd_rd !== exp_rd || sd_wr !== !exp_rd || busy !== 1'b1) held = 1'b0;
    end
    checks++;
    if (!held) begin
      errors++;
      $display("FAIL issue_hold: strobe not held for %0d cycles, required held", delay);
    end
    sd_ack = 1'b1;
    #1;
    checks++;
    if (req_ack !== exp_v) begin
      errors++;
      $display("FAIL req_ack: got %b, required %b", req_ack, exp_v);
    end
    req_rd[exp_gid] = 1'b0;
    req_wr[exp_gid] = 1'b0;
    @(negedge clk);
    checks++;
    if (sd_rd !== 1'b0 || sd_wr !== 1'b0 || req_ack !== exp_v) begin
      errors++;
      $display("FAIL xfer_entry: got rd=%b wr=%b ack=%b, required 0 0 %b", sd_rd, sd_wr, req_ack, exp_v);
    end
    seen = 0;
    stray = 0;
    for (int i = 0; i < nbuf; i++) begin
      sd_buff_wr = 1'b1;
      for (int r = 0; r < N; r++) req_buff_din[r] = 8'($urandom);
      #1;
      if (req_buff_wr[exp_gid] === 1'b1) seen++;
      if ((req_buff_wr & ~exp_v) !== '0) stray++;
      checks++;
      if (sd_buff_din !== req_buff_din[exp_gid]) begin
        errors++;
        $display("FAIL buff_din: got %h, required %h", sd_buff_din, req_buff_din[exp_gid]);
      end
      @(negedge clk);
      sd_buff_wr = 1'b0;
      #1;
      if (req_buff_wr !== '0) stray++;
      @(negedge clk);
    end
    checks++;
    if (seen != nbuf || stray != 0) begin
      errors++;
      $display("FAIL buff_wr_route: got %0d pulses %0d stray, required %0d pulses 0 stray", seen, stray, nbuf);
    end
    sd_ack = 1'b0;
    @(negedge clk);
    checks++;
    if (busy !== 1'b1 || req_ack !== '0) begin
      errors++;
      $display("FAIL release: got busy=%b ack=%b, required busy=1 ack=0", busy, req_ack);
    end
    last_ptr = exp_gid;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if (sd_rd !== 1'b0 || sd_wr !== 1'b0 || sd_lba !== '0 || grant_id !== '0 || busy !== 1'b0 ||
        req_ack !== '0 || req_buff_wr !== '0 || req_err !== '0) begin
      errors++;
      $display("FAIL reset_state: got rd=%b wr=%b lba=%h gid=%0d busy=%b ack=%b bw=%b err=%b, required all 0",
               sd_rd, sd_wr, sd_lba, grant_id, busy, req_ack, req_buff_wr, req_err);
    end
    reset_n = 1'b1;
    last_ptr = N - 1;
  endtask

  task automatic test_single_read();
    @(negedge clk);
    req_lba[0] = 32'h10;
    req_rd[0] = 1'b1;
    @(negedge clk);
    checks++;
    if (sd_rd !== 1'b1 || sd_lba !== 32'h10 || grant_id !== '0) begin
      errors++;
      $display("FAIL single_latency: got rd=%b lba=%h gid=%0d, required 1 10 0", sd_rd, sd_lba, grant_id);
    end
    serve(0, 1'b1, 32'h10, 3, 0);
    @(negedge clk);
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL idle_after_release: got busy=%b, required 0", busy);
    end
  endtask

  task automatic test_contention();
    @(negedge clk);
    reset_n = 1'b0;
    req_lba[0] = 32'hA000_0001;
    req_lba[1] = 32'hB000_0002;
    req_rd = 2'b01;
    req_wr = 2'b10;
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    last_ptr = N - 1;
    for (int t = 0; t < 2; t++) begin
      int g;
      g = rr_expect(req_rd | req_wr, last_ptr);
      serve(g, req_rd[g], req_lba[g], 2, (g == 1) ? 512 : 8);
    end
  endtask

  task automatic test_reset_mid();
    int n;
    bit held_off;
    reset_clear();
    req_lba[0] = 32'hC0C0_C0C0;
    req_rd[0] = 1'b1;
    n = 0;
    while (!sd_rd && n < 50) begin
      @(negedge clk);
      n++;
    end
    sd_ack = 1'b1;
    @(negedge clk);
    reset_n = 1'b0;
    @(negedge clk);
    checks++;
    if (busy !== 1'b0 || sd_rd !== 1'b0 || req_ack !== '0 || sd_lba !== '0) begin
      errors++;
      $display("FAIL reset_mid: got busy=%b rd=%b ack=%b lba=%h, required 0 0 0 0", busy, sd_rd, req_ack, sd_lba);
    end
    reset_n = 1'b1;
    last_ptr = N - 1;
    held_off = 1'b1;
    repeat (5) begin
      @(negedge clk);
      if (sd_rd !== 1'b0 || busy !== 1'b0) held_off = 1'b0;
    end
    checks++;
    if (!held_off) begin
      errors++;
      $display("FAIL stale_ack_guard: grant made while sd_ack high, required none");
    end
    sd_ack = 1'b0;
    @(negedge clk);
    checks++;
    if (sd_rd !== 1'b1) begin
      errors++;
      $display("FAIL grant_after_ack_low: got rd=%b, required 1", sd_rd);
    end
    serve(rr_expect(req_rd | req_wr, last_ptr), 1'b1, 32'hC0C0_C0C0, 0, 0);
  endtask

  task automatic test_rd_wr_both();
    @(negedge clk);
    req_lba[0] = 32'h0000_D00D;
    req_rd[0] = 1'b1;
    req_wr[0] = 1'b1;
    serve(rr_expect(req_rd | req_wr, last_ptr), 1'b1, 32'h0000_D00D, 1, 0);
  endtask

  task automatic test_random();
    for (int it = 0; it < 40; it++) begin
      int g;
      for (int r = 0; r < N; r++) begin
        if (!(req_rd[r] || req_wr[r]) && $urandom_range(0, 1) == 1) begin
          int c;
          c = $urandom_range(1, 3);
          req_rd[r] = c[0];
          req_wr[r] = c[1];
          req_lba[r] = $urandom;
        end
      end
      if ((req_rd | req_wr) == '0) begin
        int r;
        r = $urandom_range(0, N - 1);
        req_wr[r] = 1'b1;
        req_lba[r] = $urandom;
      end
      g = rr_expect(req_rd | req_wr, last_ptr);
      serve(g, req_rd[g], req_lba[g], $urandom_range(0, 4), $urandom_range(0, 3));
    end
  endtask

  task automatic test_watchdog();
    int n;
    reset_clear();
    req_lba[0] = 32'h0000_0E0E;
    req_rd[0] = 1'b1;
    n = 0;
    while (!sd_rd && n < 50) begin
      @(negedge clk);
      n++;
    end
`ifdef SD_ARB_TIMEOUT_EN
    n = 0;
    while (sd_rd && n < 2000) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (n != 100) begin
      errors++;
      $display("FAIL timeout_len: sd_rd high %0d cycles, required 100", n);
    end
    checks++;
    if (req_err !== 2'b01 || busy !== 1'b1) begin
      errors++;
      $display("FAIL timeout_err: got err=%b busy=%b, required 01 1", req_err, busy);
    end
    req_rd[0] = 1'b0;
    @(negedge clk);
    checks++;
    if (req_err !== '0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL timeout_after: got err=%b busy=%b, required 00 0", req_err, busy);
    end
`else
    repeat (1000) @(negedge clk);
    checks++;
    if (sd_rd !== 1'b1 || req_err !== '0) begin
      errors++;
      $display("FAIL no_timeout: got rd=%b err=%b, required rd=1 err=0", sd_rd, req_err);
    end
`endif
  endtask

  initial begin
    #1_000_000;
    $display("FAIL global_timeout: simulation exceeded time limit");
    $fatal(1);
  end

  initial begin
    reset_n = 1'b0;
    req_lba = '0;
    req_rd = '0;
    req_wr = '0;
    req_buff_din = '0;
    sd_ack = 1'b0;
    sd_buff_wr = 1'b0;
    test_reset();
    test_single_read();
    test_contention();
    test_reset_mid();
    test_rd_wr_both();
    test_random();
    test_watchdog();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
